// File: rtl/contatore_riconoscimenti.sv
// contatore_riconoscimenti
//   Counts rising edges of the upstream recogniser output z over fixed windows
//   of WINDOW clocks and hands each window's (saturating) count to a slower
//   consumer over the dav_/rfd handshake.
//
// Parameters
//   N_BIT  : width of the count and of dato; the count saturates at 2^N_BIT-1
//   WINDOW : window length in clocks (>= 2)
//
// Ports
//   clock  : system clock, all state updates on posedge
//   reset_ : synchronous active-low reset
//   z      : recognition output of the upstream recogniser
//   rfd    : consumer ready-for-data, active high
//   dav_   : data available, active low, registered
//   dato   : latched window count, stable whenever dav_=0
//   ovr    : sticky overrun flag (only when RIC_OVERRUN_EN is defined)
//
// Optional feature macro: RIC_OVERRUN_EN
//   Defined     -> port ovr exists and is set by any close edge that finds the
//                  handshake busy; it clears only on reset_.
//   Not defined -> such results are dropped silently, no ovr port.
module contatore_riconoscimenti #(
  parameter int N_BIT  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             z,
  input  logic             rfd,
  output logic             dav_,
  output logic [N_BIT-1:0] dato
`ifdef RIC_OVERRUN_EN
  ,
  output logic             ovr
`endif
);

  localparam int              WC_W    = $clog2(WINDOW);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1'b1);
  localparam logic [N_BIT-1:0] CNT_MAX = {N_BIT{1'b1}};
  localparam logic [N_BIT-1:0] CNT_ONE = N_BIT'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_RFD = 2'd1,
    S_PRESENT  = 2'd2
  } state_t;

  // Saturating increment: never wraps past the all-ones value.
  function automatic logic [N_BIT-1:0] sat_inc(input logic [N_BIT-1:0] v,
                                               input logic             inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end else begin
      return v;
    end
  endfunction

  logic [WC_W-1:0]  wc_r;
  logic [N_BIT-1:0] cnt_r;
  logic             z_q_r;
  logic [N_BIT-1:0] dato_r;
  logic             dav_r;
  state_t           state_r;
  state_t           state_s;
  logic             dav_s;
  logic             load_s;
  logic             edge_s;
  logic             close_s;
  logic [N_BIT-1:0] res_s;

  // A held-high z counts once: only the 0->1 transition is an event.
  assign edge_s  = z & ~z_q_r;
  assign close_s = (wc_r == WC_LAST);
  // An edge on the close edge itself still belongs to the closing window.
  assign res_s   = sat_inc(cnt_r, edge_s);

  // Window counter, edge-detect delay and running count; never stall.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      wc_r  <= {WC_W{1'b0}};
      cnt_r <= {N_BIT{1'b0}};
      z_q_r <= 1'b0;
    end else begin
      z_q_r <= z;
      if (close_s) begin
        wc_r  <= {WC_W{1'b0}};
        cnt_r <= {N_BIT{1'b0}};
      end else begin
        wc_r  <= wc_r + WC_ONE;
        cnt_r <= res_s;
      end
    end
  end

  // Handshake next-state logic; a close edge is only taken in S_IDLE.
  always_comb begin
    state_s = state_r;
    dav_s   = 1'b1;
    load_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        dav_s = 1'b1;
        if (close_s) begin
          load_s  = 1'b1;
          state_s = S_WAIT_RFD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT_RFD: begin
        if (rfd) begin
          dav_s   = 1'b0;
          state_s = S_PRESENT;
        end else begin
          dav_s   = 1'b1;
          state_s = S_WAIT_RFD;
        end
      end
      S_PRESENT: begin
        if (!rfd) begin
          dav_s   = 1'b1;
          state_s = S_IDLE;
        end else begin
          dav_s   = 1'b0;
          state_s = S_PRESENT;
        end
      end
      default: begin
        dav_s   = 1'b1;
        state_s = S_IDLE;
      end
    endcase
  end

  // Handshake state and registered outputs; dato only moves on a load.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_r <= S_IDLE;
      dav_r   <= 1'b1;
      dato_r  <= {N_BIT{1'b0}};
    end else begin
      state_r <= state_s;
      dav_r   <= dav_s;
      if (load_s) begin
        dato_r <= res_s;
      end else begin
        dato_r <= dato_r;
      end
    end
  end

  assign dav_ = dav_r;
  assign dato = dato_r;

`ifdef RIC_OVERRUN_EN
  logic ovr_r;
  logic overrun_s;

  // A window closing while a previous result is still being handed over.
  assign overrun_s = close_s && (state_r != S_IDLE);

  // Sticky overrun flag, cleared only by reset_.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      ovr_r <= 1'b0;
    end else if (overrun_s) begin
      ovr_r <= 1'b1;
    end else begin
      ovr_r <= ovr_r;
    end
  end

  assign ovr = ovr_r;
`endif

endmodule
